prio_tree_pipe: RTL and testbench

- Next-generation NCLIC arbitration core.
- Registers per-source pending state with edge or level trigger, enable and priority. Finds the highest-priority enabled pending source through a parametrised binary comparison tree. Pipeline registers are inserted every STAGE_LEVELS tree levels.
- Presents a threshold-qualified winner (id, priority, valid) to the core interface and accepts a claim pulse that retires the reported source.

---
 rtl/prio_tree_pipe.sv | 146 ++++++++++++++
 tb/tb_prio_tree_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/prio_tree_pipe.sv
// Interrupt arbitration core: per-source pending state feeding a pipelined
// max-priority comparison tree, with claim-based retirement of the reported winner.
module prio_tree_pipe #(
  parameter int unsigned INT_AMOUNT   = 8,
  parameter int unsigned PRIORITIES   = 4,
  parameter int unsigned STAGE_LEVELS = 2,
  localparam int unsigned PRIO_W = (PRIORITIES > 1) ? $clog2(PRIORITIES) : 1,
  localparam int unsigned ID_W   = $clog2(INT_AMOUNT)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [INT_AMOUNT-1:0] irq_i,
  input  logic [INT_AMOUNT-1:0] trig_edge_i,
  input  logic [INT_AMOUNT-1:0] enable_i,
  input  logic [PRIO_W-1:0]     prio_i [INT_AMOUNT],
  input  logic [PRIO_W-1:0]     threshold_i,
  input  logic                  claim_i,
  input  logic [ID_W-1:0]       claim_id_i,
  output logic                  out_valid_o,
  output logic [ID_W-1:0]       out_id_o,
  output logic [PRIO_W-1:0]     out_prio_o,
  output logic [INT_AMOUNT-1:0] pending_o
);

  localparam int unsigned LEVELS     = ID_W;
  localparam int unsigned NLEAF      = 2 ** LEVELS;
  localparam int unsigned PIPE_DEPTH = (LEVELS + STAGE_LEVELS - 1) / STAGE_LEVELS;

  logic [INT_AMOUNT-1:0] pending_q, pending_d;
  logic [INT_AMOUNT-1:0] irq_prev_q;

  logic              leaf_v  [NLEAF];
  logic [ID_W-1:0]   leaf_id [NLEAF];
  logic [PRIO_W-1:0] leaf_pr [NLEAF];

  logic              st_v_d  [PIPE_DEPTH][NLEAF];
  logic              st_v_q  [PIPE_DEPTH][NLEAF];
  logic [ID_W-1:0]   st_id_d [PIPE_DEPTH][NLEAF];
  logic [ID_W-1:0]   st_id_q [PIPE_DEPTH][NLEAF];
  logic [PRIO_W-1:0] st_pr_d [PIPE_DEPTH][NLEAF];
  logic [PRIO_W-1:0] st_pr_q [PIPE_DEPTH][NLEAF];

  logic [NLEAF-1:0]  pend_pad;

  // A new trigger takes precedence over a claim in the same cycle.
  always_comb begin
    pending_d = pending_q;
    for (int unsigned i = 0; i < INT_AMOUNT; i++) begin
      pending_d[i] = (trig_edge_i[i] ? (irq_i[i] & ~irq_prev_q[i]) : irq_i[i]) |
                     (pending_q[i] & ~(claim_i & (claim_id_i == ID_W'(i))));
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NLEAF; k++) begin
      leaf_v[k]  = 1'b0;
      leaf_id[k] = ID_W'(k);
      leaf_pr[k] = '0;
    end
    for (int unsigned k = 0; k < INT_AMOUNT; k++) begin
      leaf_v[k]  = pending_q[k] & enable_i[k] & (prio_i[k] > threshold_i);
      leaf_pr[k] = prio_i[k];
    end
  end

  // Each stage reduces STAGE_LEVELS tree levels in place; node k merges children 2k and 2k+1.
  always_comb begin : tree_comb
    logic              wv  [NLEAF];
    logic [ID_W-1:0]   wid [NLEAF];
    logic [PRIO_W-1:0] wpr [NLEAF];
    logic              take_r;
    int unsigned       width;
    width  = NLEAF;
    take_r = 1'b0;
    for (int unsigned s = 0; s < PIPE_DEPTH; s++) begin
      for (int unsigned k = 0; k < NLEAF; k++) begin
        if (s == 0) begin
          wv[k]  = leaf_v[k];
          wid[k] = leaf_id[k];
          wpr[k] = leaf_pr[k];
        end else begin
          wv[k]  = st_v_q[(s == 0) ? 0 : s - 1][k];
          wid[k] = st_id_q[(s == 0) ? 0 : s - 1][k];
          wpr[k] = st_pr_q[(s == 0) ? 0 : s - 1][k];
        end
      end
      for (int unsigned l = 0; l < STAGE_LEVELS; l++) begin
        if (s * STAGE_LEVELS + l < LEVELS) begin
          width = width / 2;
          for (int unsigned k = 0; k < NLEAF / 2; k++) begin
            if (k < width) begin
              take_r = wv[2*k+1] & (~wv[2*k] | (wpr[2*k+1] > wpr[2*k]));
              if (take_r) begin
                wv[k]  = 1'b1;
                wid[k] = wid[2*k+1];
                wpr[k] = wpr[2*k+1];
              end else if (wv[2*k]) begin
                wv[k]  = 1'b1;
                wid[k] = wid[2*k];
                wpr[k] = wpr[2*k];
              end else begin
                wv[k]  = 1'b0;
                wid[k] = '0;
                wpr[k] = '0;
              end
            end
          end
        end
      end
      for (int unsigned k = 0; k < NLEAF; k++) begin
        st_v_d[s][k]  = (k < width) ? wv[k]  : 1'b0;
        st_id_d[s][k] = (k < width) ? wid[k] : '0;
        st_pr_d[s][k] = (k < width) ? wpr[k] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= '0;
      irq_prev_q <= '0;
      for (int unsigned s = 0; s < PIPE_DEPTH; s++) begin
        for (int unsigned k = 0; k < NLEAF; k++) begin
          st_v_q[s][k]  <= 1'b0;
          st_id_q[s][k] <= '0;
          st_pr_q[s][k] <= '0;
        end
      end
    end else begin
      pending_q  <= pending_d;
      irq_prev_q <= irq_i;
      st_v_q     <= st_v_d;
      st_id_q    <= st_id_d;
      st_pr_q    <= st_pr_d;
    end
  end

  // Results still draining for a retired source are masked here.
  assign pend_pad    = NLEAF'(pending_q);
  assign out_id_o    = st_id_q[PIPE_DEPTH-1][0];
  assign out_prio_o  = st_pr_q[PIPE_DEPTH-1][0];
  assign out_valid_o = st_v_q[PIPE_DEPTH-1][0] & pend_pad[out_id_o] &
                       ~(claim_i & (claim_id_i == out_id_o));
  assign pending_o   = pending_q;

endmodule

// File: tb/tb_prio_tree_pipe.sv
// Directed bench: an 8-source/2-levels-per-stage instance and a 5-source/1-level-per-stage one.
module tb_prio_tree_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst_a_n, irq_dummy;
  logic [7:0] irq_a, trig_a, en_a, pend_a;
  logic [1:0] prio_a [8];
  logic [1:0] thr_a, op_a;
  logic       claim_a, ov_a;
  logic [2:0] cid_a, oid_a;

  logic       rst_b_n;
  logic [4:0] irq_b, trig_b, en_b, pend_b;
  logic [1:0] prio_b [5];
  logic [1:0] thr_b, op_b;
  logic       claim_b, ov_b;
  logic [2:0] cid_b, oid_b;

  prio_tree_pipe #(.INT_AMOUNT(8), .PRIORITIES(4), .STAGE_LEVELS(2)) u_dut_a (
    .clk(clk), .reset_n(rst_a_n), .irq_i(irq_a), .trig_edge_i(trig_a), .enable_i(en_a),
    .prio_i(prio_a), .threshold_i(thr_a), .claim_i(claim_a), .claim_id_i(cid_a),
    .out_valid_o(ov_a), .out_id_o(oid_a), .out_prio_o(op_a), .pending_o(pend_a)
  );

  prio_tree_pipe #(.INT_AMOUNT(5), .PRIORITIES(4), .STAGE_LEVELS(1)) u_dut_b (
    .clk(clk), .reset_n(rst_b_n), .irq_i(irq_b), .trig_edge_i(trig_b), .enable_i(en_b),
    .prio_i(prio_b), .threshold_i(thr_b), .claim_i(claim_b), .claim_id_i(cid_b),
    .out_valid_o(ov_b), .out_id_o(oid_b), .out_prio_o(op_b), .pending_o(pend_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_a;
    irq_a = '0; trig_a = '0; en_a = '0; thr_a = '0; claim_a = 1'b0; cid_a = '0;
    for (int i = 0; i < 8; i++) prio_a[i] = 2'd0;
  endtask

  task automatic clear_b;
    irq_b = '0; trig_b = '0; en_b = '0; thr_b = '0; claim_b = 1'b0; cid_b = '0;
    for (int i = 0; i < 5; i++) prio_b[i] = 2'd0;
  endtask

  task automatic reset_a;
    clear_a();
    rst_a_n = 1'b0;
    repeat (2) tick();
    rst_a_n = 1'b1;
  endtask

  task automatic test_reset;
    clear_a();
    clear_b();
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (2) tick();
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", ov_a); end
    checks++; if (oid_a !== 3'd0) begin errors++; $display("FAIL reset_id got %0h exp 0", oid_a); end
    checks++; if (op_a !== 2'd0) begin errors++; $display("FAIL reset_prio got %0h exp 0", op_a); end
    checks++; if (pend_a !== 8'h00) begin errors++; $display("FAIL reset_pend got %0h exp 0", pend_a); end
    checks++; if (ov_b !== 1'b0) begin errors++; $display("FAIL reset_valid_b got %0h exp 0", ov_b); end
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
  endtask

  task automatic test_level_latency;
    reset_a();
    en_a = 8'hFF;
    prio_a[2] = 2'd3; prio_a[4] = 2'd2; prio_a[5] = 2'd1;
    irq_a = 8'hFF;
    tick();
    checks++; if (pend_a !== 8'hFF) begin errors++; $display("FAIL lvl_pend got %0h exp ff", pend_a); end
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL lvl_valid_c1 got %0h exp 0", ov_a); end
    tick();
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL lvl_valid_c2 got %0h exp 0", ov_a); end
    tick();
    checks++; if (ov_a !== 1'b1) begin errors++; $display("FAIL lvl_valid_c3 got %0h exp 1", ov_a); end
    checks++; if (oid_a !== 3'd2) begin errors++; $display("FAIL lvl_id got %0h exp 2", oid_a); end
    checks++; if (op_a !== 2'd3) begin errors++; $display("FAIL lvl_prio got %0h exp 3", op_a); end
  endtask

  // Continues from test_level_latency state.
  task automatic test_threshold;
    thr_a = 2'd3;
    repeat (2) tick();
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL thr3_valid got %0h exp 0", ov_a); end
    thr_a = 2'd2;
    tick();
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL thr2_early got %0h exp 0", ov_a); end
    tick();
    checks++; if (ov_a !== 1'b1) begin errors++; $display("FAIL thr2_valid got %0h exp 1", ov_a); end
    checks++; if (oid_a !== 3'd2) begin errors++; $display("FAIL thr2_id got %0h exp 2", oid_a); end
  endtask

  task automatic test_tie_claim;
    reset_a();
    trig_a = 8'hFF; en_a = 8'hFF;
    for (int i = 0; i < 8; i++) prio_a[i] = 2'd1;
    prio_a[1] = 2'd3; prio_a[6] = 2'd3;
    irq_a = 8'h42;
    tick();
    checks++; if (pend_a !== 8'h42) begin errors++; $display("FAIL tie_pend got %0h exp 42", pend_a); end
    repeat (2) tick();
    checks++; if (ov_a !== 1'b1) begin errors++; $display("FAIL tie_valid got %0h exp 1", ov_a); end
    checks++; if (oid_a !== 3'd1) begin errors++; $display("FAIL tie_id got %0h exp 1", oid_a); end
    claim_a = 1'b1; cid_a = 3'd1;
    #1;
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL claim_mask got %0h exp 0", ov_a); end
    tick();
    claim_a = 1'b0;
    checks++; if (pend_a !== 8'h40) begin errors++; $display("FAIL claim_pend got %0h exp 40", pend_a); end
    #1;
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL drain1_valid got %0h exp 0", ov_a); end
    tick();
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL drain2_valid got %0h exp 0", ov_a); end
    tick();
    checks++; if (ov_a !== 1'b1) begin errors++; $display("FAIL next_valid got %0h exp 1", ov_a); end
    checks++; if (oid_a !== 3'd6) begin errors++; $display("FAIL next_id got %0h exp 6", oid_a); end
    checks++; if (op_a !== 2'd3) begin errors++; $display("FAIL next_prio got %0h exp 3", op_a); end
  endtask

  task automatic test_edge_hold;
    reset_a();
    trig_a = 8'hFF; en_a = 8'hFF;
    for (int i = 0; i < 8; i++) prio_a[i] = 2'd1;
    irq_a = 8'h20;
    tick();
    checks++; if (pend_a !== 8'h20) begin errors++; $display("FAIL edge_pend got %0h exp 20", pend_a); end
    repeat (2) tick();
    claim_a = 1'b1; cid_a = 3'd5;
    tick();
    claim_a = 1'b0;
    checks++; if (pend_a !== 8'h00) begin errors++; $display("FAIL edge_claim got %0h exp 0", pend_a); end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (pend_a[5] !== 1'b0) begin
        errors++; $display("FAIL edge_held c%0d got %0h exp 0", c, pend_a[5]);
      end
    end
    irq_a = 8'h00;
    tick();
    checks++; if (pend_a !== 8'h00) begin errors++; $display("FAIL edge_fall got %0h exp 0", pend_a); end
    irq_a = 8'h20;
    tick();
    checks++; if (pend_a !== 8'h20) begin errors++; $display("FAIL edge_rise got %0h exp 20", pend_a); end
  endtask

  task automatic test_set_wins;
    reset_a();
    en_a = 8'hFF;
    for (int i = 0; i < 8; i++) prio_a[i] = 2'd1;
    irq_a = 8'h10;
    tick();
    claim_a = 1'b1; cid_a = 3'd4;
    tick();
    checks++; if (pend_a !== 8'h10) begin errors++; $display("FAIL set_wins got %0h exp 10", pend_a); end
    irq_a = 8'h00;
    tick();
    claim_a = 1'b0;
    checks++; if (pend_a !== 8'h00) begin errors++; $display("FAIL lvl_claim got %0h exp 0", pend_a); end
  endtask

  task automatic test_small_tree;
    clear_b();
    rst_b_n = 1'b0;
    tick();
    rst_b_n = 1'b1;
    trig_b = 5'h1F; en_b = 5'h1F;
    for (int i = 0; i < 5; i++) prio_b[i] = 2'd1;
    irq_b = 5'h10;
    tick();
    irq_b = 5'h00;
    checks++; if (pend_b !== 5'h10) begin errors++; $display("FAIL b_pend got %0h exp 10", pend_b); end
    repeat (2) tick();
    checks++; if (ov_b !== 1'b0) begin errors++; $display("FAIL b_early got %0h exp 0", ov_b); end
    tick();
    checks++; if (ov_b !== 1'b1) begin errors++; $display("FAIL b_valid got %0h exp 1", ov_b); end
    checks++; if (oid_b !== 3'd4) begin errors++; $display("FAIL b_id got %0h exp 4", oid_b); end
    checks++; if (op_b !== 2'd1) begin errors++; $display("FAIL b_prio got %0h exp 1", op_b); end
    claim_b = 1'b1; cid_b = 3'd5;
    #1;
    checks++; if (ov_b !== 1'b1) begin errors++; $display("FAIL b_oor_mask got %0h exp 1", ov_b); end
    tick();
    checks++; if (pend_b !== 5'h10) begin errors++; $display("FAIL b_oor5 got %0h exp 10", pend_b); end
    cid_b = 3'd7;
    tick();
    claim_b = 1'b0;
    checks++; if (pend_b !== 5'h10) begin errors++; $display("FAIL b_oor7 got %0h exp 10", pend_b); end
    checks++; if (ov_b !== 1'b1) begin errors++; $display("FAIL b_hold got %0h exp 1", ov_b); end
    rst_b_n = 1'b0;
    #1;
    checks++; if (ov_b !== 1'b0) begin errors++; $display("FAIL b_rst_valid got %0h exp 0", ov_b); end
    checks++; if (oid_b !== 3'd0) begin errors++; $display("FAIL b_rst_id got %0h exp 0", oid_b); end
    checks++; if (op_b !== 2'd0) begin errors++; $display("FAIL b_rst_prio got %0h exp 0", op_b); end
    checks++; if (pend_b !== 5'h00) begin errors++; $display("FAIL b_rst_pend got %0h exp 0", pend_b); end
    #2;
    rst_b_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (ov_b !== 1'b0) begin errors++; $display("FAIL b_post_rst c%0d got %0h exp 0", c, ov_b); end
    end
  endtask

  initial begin
    irq_dummy = 1'b0;
    test_reset();
    test_level_latency();
    test_threshold();
    test_tie_claim();
    test_edge_hold();
    test_set_wins();
    test_small_tree();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
